gb_intctl: RTL and testbench

//  Interrupt controller behind the IF (0xff0f) and IE (0xffff) I/O registers.
//  - Collects the five peripheral requests and holds them in IF; stores the enable mask in IE.
//  - Signals pending work to the CPU and arbitrates the winner by fixed priority.
//  - Sequences the CPU dispatch handshake and returns the vector low byte.
//  - Decoded selects come from the I/O address decoder; one instance per system.

---
 rtl/gb_intctl_if.sv | 38 +++
 rtl/gb_intctl.sv | 169 ++++++++++++++++
 tb/tb_gb_intctl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_intctl_if.sv
// ----------------------------------------------------------------------------
// gb_intctl_if
//   Bus/handshake bundle between the CPU side (master) and the interrupt
//   controller (slave).
//   Signals:
//     sel_if, sel_ie  decoded register selects (IF at 0xff0f, IE at 0xffff)
//     wr              one-cycle write strobe for the selected register
//     din / dout      write data / combinational read data
//     irq_in[4:0]     peripheral requests (vblank, stat, timer, serial, joypad)
//     int_pend        |(IE & IF), used for HALT wake
//     int_ack         CPU starts dispatch
//     int_take        CPU fetches the vector
//     int_vec         vector low byte
//     int_busy        controller waiting for int_take
// ----------------------------------------------------------------------------
interface gb_intctl_if;
    logic       sel_if;
    logic       sel_ie;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] irq_in;
    logic       int_pend;
    logic       int_ack;
    logic       int_take;
    logic [7:0] int_vec;
    logic       int_busy;

    modport master (
        output sel_if, sel_ie, wr, din, irq_in, int_ack, int_take,
        input  dout, int_pend, int_vec, int_busy
    );

    modport slave (
        input  sel_if, sel_ie, wr, din, irq_in, int_ack, int_take,
        output dout, int_pend, int_vec, int_busy
    );
endinterface

// File: rtl/gb_intctl.sv
// ----------------------------------------------------------------------------
// gb_intctl
//   Interrupt controller behind the IF (0xff0f) and IE (0xffff) registers.
//   Latches peripheral requests into IF, holds the enable mask in IE, flags
//   pending work to the CPU, and runs the two-step dispatch handshake
//   (int_ack, then int_take) that returns the winning vector low byte and
//   clears the winner's IF bit.
//
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      gb_intctl_if.slave (selects, write strobe/data, read data,
//              requests, pending flag, dispatch handshake, vector, busy)
//
//   Build option:
//     GB_INTCTL_EDGE_DETECT_EN  when defined, requests are registered and only
//                               a 0->1 rise sets IF (2-cycle request latency);
//                               otherwise each high cycle of irq_in sets IF.
// ----------------------------------------------------------------------------
module gb_intctl #(
    parameter int NSRC = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    gb_intctl_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [NSRC-1:0]   if_q;
    logic [NSRC-1:0]   if_d;
    logic [7:0]        ie_q;
    logic [7:0]        vec_q;
    logic [7:0]        vec_d;

    logic [NSRC-1:0]   set;
    logic [NSRC-1:0]   clr;
    logic [NSRC-1:0]   pend;
    logic [NSRC-1:0]   win_onehot;
    logic [7:0]        win_vec;
    logic              if_wr;
    logic              ie_wr;

    assign if_wr = bus.wr & bus.sel_if;
    assign ie_wr = bus.wr & bus.sel_ie;

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
`ifdef GB_INTCTL_EDGE_DETECT_EN
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] rise_q;

    // The rise is registered so a held-high request sets IF exactly once,
    // two cycles after irq_in goes high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q  <= '0;
            rise_q <= '0;
        end else begin
            irq_q  <= bus.irq_in;
            rise_q <= bus.irq_in & ~irq_q;
        end
    end

    assign set = rise_q;
`else
    // Sources deliver one-cycle strobes; a held level re-sets IF every cycle.
    assign set = bus.irq_in;
`endif

    // ------------------------------------------------------------------------
    // Arbitration: lowest set bit of IE & IF wins. Not frozen at int_ack, so
    // a change to IE or IF during WAIT changes the outcome at int_take.
    // ------------------------------------------------------------------------
    assign pend       = ie_q[NSRC-1:0] & if_q;
    assign win_onehot = pend & (~pend + 1'b1);

    always_comb begin
        win_vec = 8'h00;
        // Descending scan so the lowest pending bit is the last to assign.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_vec = 8'(8'h40 + 8 * i);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Dispatch FSM, next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        vec_d   = vec_q;
        clr     = '0;

        unique case (state_q)
            ST_IDLE: begin
                // int_take without a preceding int_ack is ignored here.
                if (bus.int_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A second int_ack while waiting is ignored.
                if (bus.int_take) begin
                    vec_d   = win_vec;
                    clr     = win_onehot;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CPU write to IF overrides the dispatch clear; a hardware set
        // always wins over both.
        if (if_wr) begin
            if_d = bus.din[NSRC-1:0] | set;
        end else begin
            if_d = (if_q & ~clr) | set;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            if_q    <= '0;
            ie_q    <= 8'h00;
            vec_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if_q    <= if_d;
            vec_q   <= vec_d;
            if (ie_wr) begin
                ie_q <= bus.din;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.dout = 8'h00;
        if (bus.sel_if) begin
            // Unimplemented upper IF bits read as 1.
            bus.dout = {{(8 - NSRC){1'b1}}, if_q};
        end else if (bus.sel_ie) begin
            bus.dout = ie_q;
        end
    end

    assign bus.int_pend = |pend;
    assign bus.int_vec  = vec_q;
    assign bus.int_busy = (state_q == ST_WAIT);

endmodule

// File: tb/tb_gb_intctl.sv
// ----------------------------------------------------------------------------
// tb_gb_intctl
//   Self-checking bench for gb_intctl. A small register model tracks IF/IE;
//   each dispatch pushes its expected vector and IF into a scoreboard queue
//   when int_take is driven, and pops/compares once the DUT has updated.
// ----------------------------------------------------------------------------
module tb_gb_intctl;

    logic clk;
    logic reset_n;

    gb_intctl_if bus ();

    gb_intctl #(.NSRC(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        logic [4:0] ifv;
    } exp_t;

    exp_t sb[$];

    int         total = 0;
    int         bad   = 0;
    logic [4:0] m_if  = 5'h00;
    logic [7:0] m_ie  = 8'h00;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // Independent reference for the vector table.
    function automatic logic [7:0] ref_vec(input logic [4:0] p);
        casez (p)
            5'b????1: return 8'h40;
            5'b???10: return 8'h48;
            5'b??100: return 8'h50;
            5'b?1000: return 8'h58;
            5'b10000: return 8'h60;
            default:  return 8'h00;
        endcase
    endfunction

    function automatic logic [4:0] ref_onehot(input logic [4:0] p);
        for (int i = 0; i < 5; i++) begin
            if (p[i]) return 5'(1 << i);
        end
        return 5'h00;
    endfunction

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_reg(input bit to_ie, input logic [7:0] data);
        bus.sel_ie = to_ie;
        bus.sel_if = !to_ie;
        bus.wr     = 1'b1;
        bus.din    = data;
        tick();
        bus.sel_ie = 1'b0;
        bus.sel_if = 1'b0;
        bus.wr     = 1'b0;
        if (to_ie) m_ie = data;
        else       m_if = data[4:0];
    endtask

    task automatic check_if(input string tag);
        bus.sel_if = 1'b1;
        #1;
        check(tag, bus.dout, {3'b111, m_if});
        bus.sel_if = 1'b0;
        #1;
    endtask

    task automatic irq_latency();
`ifdef GB_INTCTL_EDGE_DETECT_EN
        tick();
`endif
    endtask

    task automatic pulse_irq(input logic [4:0] v);
        bus.irq_in = v;
        tick();
        bus.irq_in = 5'h00;
        irq_latency();
        m_if = m_if | v;
    endtask

    // int_ack, optional IE write in WAIT, int_take with optional IF write.
    task automatic dispatch(input string tag, input bit ie_wr, input logic [7:0] ie_val,
                            input bit if_wr, input logic [7:0] if_val);
        exp_t e;
        logic [4:0] p;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check({tag, "_busy_wait"}, {7'd0, bus.int_busy}, 8'h01);
        if (ie_wr) write_reg(1'b1, ie_val);
        else       tick();
        p     = m_ie[4:0] & m_if;
        e.vec = ref_vec(p);
        e.ifv = if_wr ? if_val[4:0] : (m_if & ~ref_onehot(p));
        sb.push_back(e);
        bus.int_take = 1'b1;
        if (if_wr) begin
            bus.sel_if = 1'b1;
            bus.wr     = 1'b1;
            bus.din    = if_val;
        end
        tick();
        bus.int_take = 1'b0;
        bus.sel_if   = 1'b0;
        bus.wr       = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            e    = sb.pop_front();
            m_if = e.ifv;
            check({tag, "_vec"}, bus.int_vec, e.vec);
            check({tag, "_busy_idle"}, {7'd0, bus.int_busy}, 8'h00);
            check_if({tag, "_if"});
            check({tag, "_pend"}, {7'd0, bus.int_pend}, {7'd0, |(m_ie[4:0] & m_if)});
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.sel_if   = 1'b0;
        bus.sel_ie   = 1'b0;
        bus.wr       = 1'b0;
        bus.din      = 8'h00;
        bus.irq_in   = 5'h00;
        bus.int_ack  = 1'b0;
        bus.int_take = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1. Reset state and read mux.
        bus.sel_if = 1'b1; #1;
        check("rst_if_read", bus.dout, 8'hE0);
        bus.sel_if = 1'b0; bus.sel_ie = 1'b1; #1;
        check("rst_ie_read", bus.dout, 8'h00);
        bus.sel_ie = 1'b0; #1;
        check("rst_no_sel", bus.dout, 8'h00);
        check("rst_vec", bus.int_vec, 8'h00);
        check("rst_busy", {7'd0, bus.int_busy}, 8'h00);
        check("rst_pend", {7'd0, bus.int_pend}, 8'h00);

        // 2. Timer request, single dispatch; int_take in IDLE ignored.
        write_reg(1'b1, 8'h1F);
        bus.int_take = 1'b1;
        tick();
        bus.int_take = 1'b0;
        check("idle_take_vec", bus.int_vec, 8'h00);
        pulse_irq(5'b00100);
        check_if("t2_if_set");
        check("t2_pend", {7'd0, bus.int_pend}, 8'h01);
        dispatch("t2", 1'b0, 8'h00, 1'b0, 8'h00);

        // 3. Priority: stat before joypad.
        write_reg(1'b0, 8'h12);
        dispatch("t3a", 1'b0, 8'h00, 1'b0, 8'h00);
        dispatch("t3b", 1'b0, 8'h00, 1'b0, 8'h00);

        // 4. IE cleared during WAIT: no winner, IF untouched.
        write_reg(1'b0, 8'h01);
        write_reg(1'b1, 8'h01);
        dispatch("t4", 1'b1, 8'h00, 1'b0, 8'h00);
        bus.sel_ie = 1'b1; #1;
        check("t4_ie_read", bus.dout, 8'h00);
        bus.sel_ie = 1'b0; #1;

        // 5. Hardware set wins over a same-cycle write; take with IF write.
        bus.sel_if    = 1'b1;
        bus.wr        = 1'b1;
        bus.din       = 8'h00;
        bus.irq_in    = 5'b00001;
        tick();
        bus.sel_if    = 1'b0;
        bus.wr        = 1'b0;
        bus.irq_in    = 5'h00;
        irq_latency();
        m_if = 5'h01;
        check_if("t5_set_wins");
        write_reg(1'b1, 8'h1F);
        dispatch("t5_take_wr", 1'b0, 8'h00, 1'b1, 8'h1F);

        // 6. Held request with a clear part-way through.
        write_reg(1'b0, 8'h00);
        for (int c = 0; c < 10; c++) begin
            bus.irq_in = 5'b01000;
            if (c == 5) begin
                bus.sel_if = 1'b1;
                bus.wr     = 1'b1;
                bus.din    = 8'h00;
            end
            tick();
            bus.sel_if = 1'b0;
            bus.wr     = 1'b0;
            if (c == 5) begin
`ifdef GB_INTCTL_EDGE_DETECT_EN
                m_if = 5'h00;
`else
                m_if = 5'h08;
`endif
                check_if("t6_after_clear");
            end
        end
        check_if("t6_after_hold");
        bus.irq_in = 5'h00;
        tick();
        irq_latency();
        write_reg(1'b0, 8'h00);

        // Reset asserted in WAIT.
        write_reg(1'b0, 8'h01);
        write_reg(1'b1, 8'h01);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check("t6_busy_before_rst", {7'd0, bus.int_busy}, 8'h01);
        reset_n = 1'b0;
        #1;
        m_if = 5'h00;
        m_ie = 8'h00;
        check("t6_rst_busy", {7'd0, bus.int_busy}, 8'h00);
        check_if("t6_rst_if");
        check("t6_rst_pend", {7'd0, bus.int_pend}, 8'h00);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_post_rst_busy", {7'd0, bus.int_busy}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
